serial_adder_ctrl: RTL and testbench

Bit-serial add/subtract sequencer that drives a single existing `fullAdder` cell over WIDTH clock cycles, one bit per cycle, LSB first. It latches operands on a start handshake, shifts them through the adder with a registered carry, and assembles the WIDTH-bit result plus carry-out. It serves the game logic (score and row-counter updates) where area matters more than latency.

---
 rtl/serial_adder_pkg.sv | 4 +
 rtl/serial_adder_ctrl_if.sv | 7 +
 rtl/fullAdder.sv | 11 +
 rtl/serial_adder_ctrl.sv | 57 +++++
 tb/tb_serial_adder_ctrl.sv | 99 +++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types for the bit-serial add/subtract sequencer.
package serial_adder_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: operand/result handshake between a requester and the serial adder.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
    logic             start, sub, cin, busy, done, cout;
    logic [WIDTH-1:0] a, b, sum;
    modport master(output start, sub, a, b, cin, input busy, done, sum, cout);
    modport slave(input start, sub, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/fullAdder.sv
// fullAdder: single-bit full adder cell, the only arithmetic in the serial datapath.
module fullAdder (
    output logic sum,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial add/subtract over WIDTH cycles through one fullAdder.
module serial_adder_ctrl #(parameter int WIDTH = 8) (
    input logic            clk,
    input logic            reset,
    serial_adder_ctrl_if.slave bus
);
    import serial_adder_pkg::*;
    localparam int CW = $clog2(WIDTH);
    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a, op_b, res, res_nx;
    logic             carry, fa_s, fa_c, last;
    fullAdder u_fa (.sum(fa_s), .cout(fa_c), .a(op_a[0]), .b(op_b[0]), .cin(carry));
    always_comb begin
        last     = cnt == CW'(WIDTH - 1);
        // sum bit enters at the MSB; the LSB falls off the end
        res_nx   = WIDTH'({fa_s, res} >> 1);
        state_nx = state == IDLE ? (bus.start ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            carry    <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            res      <= '0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            state    <= state_nx;
            bus.busy <= state_nx != IDLE;
            bus.done <= state_nx == DONE;
            if (state == IDLE && bus.start) begin
                op_a  <= bus.a;
                op_b  <= bus.sub ? ~bus.b : bus.b;
                carry <= bus.sub | bus.cin;
                cnt   <= '0;
                res   <= '0;
            end
            if (state == RUN) begin
                res   <= res_nx;
                op_a  <= op_a >> 1;
                op_b  <= op_b >> 1;
                carry <= fa_c;
                cnt   <= cnt + CW'(1);
                if (last) begin
                    bus.sum  <= res_nx;
                    bus.cout <= fa_c;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of latency, add/sub results, start masking, async reset and back-to-back runs.
module tb_serial_adder_ctrl;
    localparam int W = 8;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [W-1:0] prev_sum = '0;
    serial_adder_ctrl_if #(.WIDTH(W)) bus();
    serial_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts,
                      input logic [W-1:0] es, input logic ec, input string tag, input bit intrude);
        int n = 0;
        bit saw = 0;
        @(negedge clk);
        bus.a = ta; bus.b = tb; bus.cin = tc; bus.sub = ts; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        chk({tag, "_busy_rise"}, 32'(bus.busy), 1);
        while (!bus.done && n < 20) begin
            if (n == 4) chk({tag, "_sum_hold"}, 32'(bus.sum), 32'(prev_sum));
            if (intrude && n == 2) begin bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01; end
            if (intrude && n == 5) bus.start = 1'b0;
            @(posedge clk); #1 n++;
        end
        chk({tag, "_latency"}, 32'(n), W);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        chk({tag, "_busy_done"}, 32'(bus.busy), 1);
        prev_sum = es;
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(bus.done), 0);
        chk({tag, "_busy_fall"}, 32'(bus.busy), 0);
        if (intrude) begin
            repeat (12) begin @(posedge clk); #1 if (bus.done) saw = 1; end
            chk({tag, "_no_second_done"}, 32'(saw), 0);
            chk({tag, "_sum_kept"}, 32'(bus.sum), 32'(es));
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        @(negedge clk);
        chk("rst_sum", 32'(bus.sum), 0);
        chk("rst_cout", 32'(bus.cout), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        reset = 1'b0;
        op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, "add", 1);
        op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "wrap", 0);
        op(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, "wrap_cin", 0);
        op(8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, "sub", 0);
        // abort an operation mid-RUN with an asynchronous reset
        @(negedge clk);
        bus.a = 8'h5A; bus.b = 8'h3C; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_sum", 32'(bus.sum), 0);
        chk("midrst_cout", 32'(bus.cout), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_done", 32'(bus.done), 0);
        @(negedge clk) reset = 1'b0;
        n = 0;
        repeat (12) begin @(posedge clk); #1 if (bus.done || bus.busy) n++; end
        chk("midrst_idle", 32'(n), 0);
        prev_sum = '0;
        op(8'h22, 8'h11, 1'b0, 1'b0, 8'h33, 1'b0, "fresh", 0);
        op(8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, "borrow", 0);
        // start held high: one result every WIDTH+2 cycles
        @(negedge clk);
        bus.a = 8'h03; bus.b = 8'h04; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
        n = 0;
        while (!bus.done && n < 40) begin @(posedge clk); #1 n++; end
        chk("b2b_first_done", 32'(bus.done), 1);
        chk("b2b_sum0", 32'(bus.sum), 8'h07);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin @(posedge clk); #1 n++; end while (!bus.done && n < 20);
            chk($sformatf("b2b_period%0d", k), 32'(n), W + 2);
            chk($sformatf("b2b_sum%0d", k + 1), 32'(bus.sum), 8'h07);
        end
        bus.start = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
